// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer and its next-PC mux.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } pc_state_t;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam int unsigned PC_INCR = 4;

    // Jump outranks a taken branch; 2'b11 is never produced.
    function automatic logic [1:0] decode_pc_src(input logic branch,
                                                 input logic branch_taken,
                                                 input logic jump);
        logic [1:0] src;
        src = PC_SRC_SEQ;
        if (jump) begin
            src = PC_SRC_JUMP;
        end else if (branch && branch_taken) begin
            src = PC_SRC_BRANCH;
        end
        return src;
    endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_mux.sv
// NextPCMux: picks the sequential, branch or jump target as next_pc.
module pc_sequencer_next_pc_mux
    import pc_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc_plus_4,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jump_target,
    input  logic [1:0]      pc_src,
    output logic [XLEN-1:0] next_pc
);

    // Select the next PC; the unused 2'b11 code falls back to sequential flow.
    always_comb begin
        next_pc = pc_plus_4;
        case (pc_src)
            PC_SRC_BRANCH: next_pc = branch_target;
            PC_SRC_JUMP:   next_pc = jump_target;
            default:       next_pc = pc_plus_4;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: owns the architectural PC, sequences stall/halt/resume,
// traps misaligned redirects and counts retired instructions.
//
// state | meaning
// BOOT  | single cycle after reset release, PC held at RESET_VECTOR
// RUN   | normal flow, one instruction may commit per cycle
// STALL | datapath not ready, PC held until stall drops
// HALT  | debug halt or misaligned trap, PC held until resume
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch,
    input  logic            branch_taken,
    input  logic            jump,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jump_target,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_4,
    output logic [1:0]      pc_src,
    output logic            instr_valid,
    output logic            halted,
    output logic            misaligned_trap,
    output logic [31:0]     instret
);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instret_q, instret_d;
    logic            trap_q, trap_d;
    logic [XLEN-1:0] next_pc;
    logic            active;
    logic            redirect;
    logic            misalign;
    logic            advance;

    assign active    = (state_q == RUN) || (state_q == STALL);
    assign pc_plus_4 = pc_q + XLEN'(PC_INCR);

    // Redirect select is only meaningful while instructions can commit.
    always_comb begin
        pc_src = PC_SRC_SEQ;
        if (active) begin
            pc_src = decode_pc_src(branch, branch_taken, jump);
        end
    end

    pc_sequencer_next_pc_mux #(
        .XLEN(XLEN)
    ) u_next_pc_mux (
        .pc_plus_4    (pc_plus_4),
        .branch_target(branch_target),
        .jump_target  (jump_target),
        .pc_src       (pc_src),
        .next_pc      (next_pc)
    );

    assign redirect = (pc_src != PC_SRC_SEQ);
    assign misalign = redirect && (next_pc[1:0] != 2'b00);
    assign advance  = active && !stall && !halt_req && !misalign;

    // Next-state logic: halt_req beats misalign beats stall beats commit.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        trap_d    = trap_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN, STALL: begin
                if (halt_req) begin
                    state_d = HALT;
                end else if (misalign) begin
                    state_d = HALT;
                    trap_d  = 1'b1;
                end else if (stall) begin
                    state_d = STALL;
                end else begin
                    state_d = RUN;
                end
            end
            HALT: begin
                if (resume && !halt_req) begin
                    state_d = RUN;
                    trap_d  = 1'b0;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        if (advance) begin
            pc_d      = next_pc;
            instret_d = instret_q + 32'd1;
        end
    end

    // State, PC, retire counter and trap flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_VECTOR;
            instret_q <= '0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
            trap_q    <= trap_d;
        end
    end

    assign pc              = pc_q;
    assign instret         = instret_q;
    assign misaligned_trap = trap_q;
    assign halted          = (state_q == HALT);
    assign instr_valid     = advance;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the architectural PC register of the single-cycle RISC-V core and sequences instruction flow.
- Each cycle it decides whether the PC advances and derives the 2-bit pc_src select from the branch and jump decode signals.
- Instantiates the core's NextPCMux to form next_pc.
- Adds stall, halt/resume and misaligned-target trap handling, plus a retired-instruction counter.
- Sits between control/ALU-compare logic and instruction memory.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- XLEN, 32, PC and target width.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  datapath not ready; hold PC.
- branch  input  1  current instruction is a conditional branch.
- branch_taken  input  1  branch comparison true.
- jump  input  1  current instruction is JAL/JALR.
- branch_target  input  XLEN  branch destination.
- jump_target  input  XLEN  jump destination.
- halt_req  input  1  debug halt request, level-sensitive.
- resume  input  1  leave HALT, single-cycle pulse.
- pc  output  XLEN  current PC, registered.
- pc_plus_4  output  XLEN  pc + 4, combinational.
- pc_src  output  2  select driven to NextPCMux.
- instr_valid  output  1  instruction at pc commits this cycle.
- halted  output  1  FSM is in HALT.
- misaligned_trap  output  1  sticky flag: a redirect target had bits [1:0] != 0.
- instret  output  32  count of committed instructions.

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - pc=RESET_VECTOR, state=BOOT.
  - pc_src=00, instr_valid=0, halted=0, misaligned_trap=0, instret=0.
- pc_src decode, a pure function of the inputs:
  - jump=1 -> 10.
  - else branch & branch_taken -> 01.
  - else 00.
  - Jump has priority over branch. Code 11 is never driven.
  - Forced to 00 in BOOT and HALT.
- pc_plus_4 = pc + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0 with no flag.
- redirect = pc_src != 00. misalign = redirect & (next_pc[1:0] != 0).
- advance = (state RUN or STALL) & !stall & !halt_req & !misalign.
- On advance:
  - pc <= next_pc, instret <= instret + 1 (wraps).
  - instr_valid=1 in the same cycle, combinationally.
- FSM:
  - BOOT: exactly one cycle after rst_n deasserts; pc held; always goes to RUN.
  - RUN:
    - halt_req -> HALT (highest priority).
    - else misalign -> HALT, set misaligned_trap, pc unchanged.
    - else stall -> STALL.
    - else advance, stay in RUN.
  - STALL: same priority list as RUN; when stall drops, advance and go to RUN. Inputs are re-evaluated in the release cycle (the datapath holds them stable).
  - HALT:
    - halted=1, pc held, instr_valid=0.
    - resume & !halt_req -> RUN and clear misaligned_trap.
    - resume while halt_req=1 is ignored.
- Simultaneous halt_req and stall: HALT wins.
- halt_req arriving in BOOT is honoured on the first RUN cycle, so no instruction commits.
- Reset mid-stall or mid-halt returns to BOOT/RESET_VECTOR immediately and clears the counters and flags.
- Latency: a redirect is visible on pc the cycle after commit. No delay slots.

Decomposition:
- pc_seq_pkg holds:
  - typedef enum logic [1:0] {BOOT, RUN, STALL, HALT} pc_state_t.
  - localparams PC_SRC_SEQ=2'b00, PC_SRC_BRANCH=2'b01, PC_SRC_JUMP=2'b10.
  - constant PC_INCR=4.
- Sub-module: one NextPCMux instance (pc_plus_4, branch_target, jump_target, pc_src -> next_pc). No other hierarchy.

Test Plan:
1. Reset release, RESET_VECTOR=0, no redirects, 4 cycles:
   - BOOT cycle with pc=0 and instr_valid=0.
   - Then pc=0,4,8,12 with instr_valid=1.
   - instret=3 after the third advance.
2. At pc=8, branch=1, branch_taken=1, branch_target=200: pc_src=01, next cycle pc=200. Repeat with branch_taken=0 -> pc=12.
3. Jump priority: jump=1 with jump_target=512, plus branch=1, branch_taken=1, branch_target=200:
   - pc_src=10, next pc=512.
   - Then jump_target=514 -> halted=1, misaligned_trap=1, pc stays 512.
   - resume pulse -> trap cleared, state RUN.
4. Stall 3 cycles at pc=100 while jump=1, jump_target=300:
   - pc held at 100 and instr_valid=0 for 3 cycles.
   - Release cycle commits, then pc=300; instret increments once.
5. halt_req and stall asserted together at pc=40:
   - HALT entered, pc=40.
   - resume while halt_req=1 is ignored.
   - Drop halt_req, pulse resume -> pc advances to 44.
6. rst_n low for 1 cycle while in STALL with pc=0x80 and instret=5: all outputs return to reset values asynchronously, before the next clock edge.
